// File: rtl/timer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | timer_pkg : shared types, digit limits and cursor helpers            |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
package timer_pkg;

    localparam int TIME_W   = 36;
    localparam int N_DIGITS = 9;

    // Cursor positions, 0 is the leftmost displayed digit
    localparam logic [2:0] DIG_H2 = 3'd0;
    localparam logic [2:0] DIG_H1 = 3'd1;
    localparam logic [2:0] DIG_M2 = 3'd2;
    localparam logic [2:0] DIG_M1 = 3'd3;
    localparam logic [2:0] DIG_S2 = 3'd4;
    localparam logic [2:0] DIG_S1 = 3'd5;

    localparam logic [3:0] LIM_MS = 4'd9;
    localparam logic [3:0] LIM_S1 = 4'd9;
    localparam logic [3:0] LIM_S2 = 4'd5;
    localparam logic [3:0] LIM_M1 = 4'd9;
    localparam logic [3:0] LIM_M2 = 4'd5;
    localparam logic [3:0] LIM_H1 = 4'd9;
    localparam logic [3:0] LIM_H2 = 4'd9;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_EDIT  = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } ch_state_t;

    typedef enum logic [2:0] {
        CMD_NONE        = 3'd0,
        CMD_ENTER_KEEP  = 3'd1,
        CMD_ENTER_CLEAR = 3'd2,
        CMD_INC         = 3'd3,
        CMD_DEC         = 3'd4,
        CMD_EXIT        = 3'd5,
        CMD_TOGGLE      = 3'd6
    } ch_cmd_t;

    // Nibble 0 is ms1 (LSB), nibble 8 is H2 (MSB)
    function automatic logic [3:0] nib_limit(input int n);
        case (n)
            0, 1, 2: nib_limit = LIM_MS;
            3:       nib_limit = LIM_S1;
            4:       nib_limit = LIM_S2;
            5:       nib_limit = LIM_M1;
            6:       nib_limit = LIM_M2;
            7:       nib_limit = LIM_H1;
            default: nib_limit = LIM_H2;
        endcase
    endfunction

    function automatic int cursor_nib(input logic [2:0] c);
        case (c)
            DIG_H2:  cursor_nib = 8;
            DIG_H1:  cursor_nib = 7;
            DIG_M2:  cursor_nib = 6;
            DIG_M1:  cursor_nib = 5;
            DIG_S2:  cursor_nib = 4;
            DIG_S1:  cursor_nib = 3;
            default: cursor_nib = 3;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/multi_timer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | multi_timer_if : button/select inputs and display/status outputs     |
// | Revision       : 1.0                                                 |
// +----------------------------------------------------------------------+
interface multi_timer_if #(
    parameter int N_CH = 4
);
    localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [SEL_W-1:0] sel;
    logic             bC;
    logic             bL;
    logic             bD;
    logic             bR;
    logic             start;
    logic [35:0]      out_o;
    logic [2:0]       curr_digit;
    logic             edit;
    logic [N_CH-1:0]  done;
    logic [N_CH-1:0]  running;

    modport master (
        output sel, bC, bL, bD, bR, start,
        input  out_o, curr_digit, edit, done, running
    );

    modport slave (
        input  sel, bC, bL, bD, bR, start,
        output out_o, curr_digit, edit, done, running
    );
endinterface
`default_nettype wire

// File: rtl/timer_channel.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | timer_channel : one BCD countdown channel with digit editing         |
// | Revision      : 1.0                                                  |
// +----------------------------------------------------------------------+
module timer_channel
    import timer_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_tick,
    input  ch_cmd_t           i_cmd,
    input  logic [2:0]        i_digit,
    output ch_state_t         o_state,
    output logic [TIME_W-1:0] o_time
);

    ch_state_t         r_state;
    ch_state_t         w_state_nxt;
    logic [TIME_W-1:0] r_time;
    logic [TIME_W-1:0] w_time_nxt;
    logic [TIME_W-1:0] w_dec_time;
    logic [TIME_W-1:0] w_edit_time;
    logic              w_borrow;
    logic [3:0]        w_cur_d;
    logic [3:0]        w_lim;
    int                w_nib;

    // 1 ms BCD decrement, borrowing through the per-digit limits
    always_comb begin
        w_dec_time = r_time;
        w_borrow   = 1'b1;
        for (int n = 0; n < N_DIGITS; n++) begin
            if (w_borrow) begin
                if (r_time[4*n +: 4] == 4'd0) begin
                    w_dec_time[4*n +: 4] = nib_limit(n);
                end else begin
                    w_dec_time[4*n +: 4] = r_time[4*n +: 4] - 4'd1;
                    w_borrow             = 1'b0;
                end
            end
        end
    end

    always_comb begin
        w_nib       = cursor_nib(i_digit);
        w_cur_d     = r_time[4*w_nib +: 4];
        w_lim       = nib_limit(w_nib);
        w_edit_time = r_time;
        if (i_cmd == CMD_INC) begin
            w_edit_time[4*w_nib +: 4] = (w_cur_d >= w_lim) ? 4'd0 : w_cur_d + 4'd1;
        end else begin
            w_edit_time[4*w_nib +: 4] = (w_cur_d == 4'd0) ? w_lim : w_cur_d - 4'd1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_time_nxt  = r_time;
        case (i_cmd)
            CMD_ENTER_KEEP: begin
                w_state_nxt = ST_EDIT;
                w_time_nxt  = {r_time[TIME_W-1:12], 12'd0};
            end
            CMD_ENTER_CLEAR: begin
                w_state_nxt = ST_EDIT;
                w_time_nxt  = '0;
            end
            CMD_INC, CMD_DEC: begin
                if (r_state == ST_EDIT) w_time_nxt = w_edit_time;
            end
            CMD_EXIT: begin
                if (r_state == ST_EDIT) w_state_nxt = (r_time != '0) ? ST_RUN : ST_IDLE;
            end
            CMD_TOGGLE: begin
                if (r_state == ST_RUN)        w_state_nxt = ST_PAUSE;
                else if (r_state == ST_PAUSE) w_state_nxt = ST_RUN;
            end
            default: begin
                if (i_tick && (r_state == ST_RUN)) begin
                    w_time_nxt = w_dec_time;
                    if (w_dec_time == '0) w_state_nxt = ST_DONE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_time  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_time  <= w_time_nxt;
        end
    end

    assign o_state = r_state;
    assign o_time  = r_time;

endmodule
`default_nettype wire

// File: rtl/multi_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | multi_timer : N-channel BCD countdown timer with shared 1 ms tick    |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module multi_timer
    import timer_pkg::*;
#(
    parameter int N_CH     = 4,
    parameter int TICK_DIV = 100000
) (
    input  logic         clk,
    input  logic         rst_n,
    multi_timer_if.slave bus
);

    localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int PW    = $clog2(TICK_DIV);

    logic [PW-1:0]     r_presc;
    logic              w_tick;
    logic [2:0]        r_digit;
    logic [2:0]        w_digit_nxt;

    ch_state_t         w_state [N_CH];
    logic [TIME_W-1:0] w_time  [N_CH];
    ch_cmd_t           w_ch_cmd[N_CH];

    logic              w_edit_any;
    logic [SEL_W-1:0]  w_edit_idx;
    logic [SEL_W-1:0]  w_addr;
    logic              w_addr_ok;
    ch_state_t         w_sel_state;
    logic [TIME_W-1:0] w_time_sel;
    logic              w_sel_edit;
    ch_cmd_t           w_cmd;
    logic [N_CH-1:0]   w_done;
    logic [N_CH-1:0]   w_running;

    assign w_tick = (r_presc == PW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      r_presc <= '0;
        else if (w_tick) r_presc <= '0;
        else             r_presc <= r_presc + PW'(1);
    end

    // At most one channel can be in EDIT, because sel is frozen while editing
    always_comb begin
        w_edit_any = 1'b0;
        w_edit_idx = '0;
        w_done     = '0;
        w_running  = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (w_state[i] == ST_EDIT) begin
                w_edit_any = 1'b1;
                w_edit_idx = SEL_W'(i);
            end
            w_done[i]    = (w_state[i] == ST_DONE);
            w_running[i] = (w_state[i] == ST_RUN);
        end
    end

    assign w_addr = w_edit_any ? w_edit_idx : bus.sel;

    always_comb begin
        w_addr_ok   = 1'b0;
        w_sel_state = ST_IDLE;
        w_time_sel  = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (w_addr == SEL_W'(i)) begin
                w_addr_ok   = 1'b1;
                w_sel_state = w_state[i];
                w_time_sel  = w_time[i];
            end
        end
    end

    assign w_sel_edit = (w_sel_state == ST_EDIT);

    // Highest-priority input wins; an issued command displaces the channel's tick
    always_comb begin
        w_cmd       = CMD_NONE;
        w_digit_nxt = r_digit;
        if (w_addr_ok) begin
            if (bus.bL) begin
                if (!w_sel_edit) begin
                    w_cmd       = CMD_ENTER_KEEP;
                    w_digit_nxt = DIG_H2;
                end else if (r_digit == DIG_H2) begin
                    w_cmd       = CMD_EXIT;
                    w_digit_nxt = DIG_H2;
                end else begin
                    w_digit_nxt = r_digit - 3'd1;
                end
            end else if (bus.bD) begin
                if (w_sel_edit) begin
                    w_cmd = CMD_DEC;
                end else begin
                    w_cmd       = CMD_ENTER_CLEAR;
                    w_digit_nxt = DIG_H2;
                end
            end else if (bus.bR) begin
                if (w_sel_edit) begin
                    if (r_digit == DIG_S1) begin
                        w_cmd       = CMD_EXIT;
                        w_digit_nxt = DIG_H2;
                    end else begin
                        w_digit_nxt = r_digit + 3'd1;
                    end
                end
            end else if (bus.bC) begin
                if (w_sel_edit) w_cmd = CMD_INC;
            end else if (bus.start) begin
                if ((w_sel_state == ST_RUN) || (w_sel_state == ST_PAUSE)) w_cmd = CMD_TOGGLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_digit <= DIG_H2;
        else        r_digit <= w_digit_nxt;
    end

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            assign w_ch_cmd[gi] = (w_addr_ok && (w_addr == SEL_W'(gi))) ? w_cmd : CMD_NONE;

            timer_channel u_ch (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_tick  (w_tick),
                .i_cmd   (w_ch_cmd[gi]),
                .i_digit (r_digit),
                .o_state (w_state[gi]),
                .o_time  (w_time[gi])
            );
        end
    endgenerate

    assign bus.out_o      = w_time_sel;
    assign bus.curr_digit = r_digit;
    assign bus.edit       = w_edit_any;
    assign bus.done       = w_done;
    assign bus.running    = w_running;

endmodule
`default_nettype wire
